cla_add_sub_pipe: RTL and testbench

//  Pipelined, parametrised successor of the combinational CLA add/sub unit for the

---
 rtl/cla_add_sub_pipe.sv | 192 +++++++++++++++++++
 tb/tb_cla_add_sub_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_sub_pipe.sv
// Pipelined carry-lookahead add/sub/compare unit for the execute stage.
// WIDTH bits are split into NSEG = WIDTH/SEG_W registered CLA segments.
// The carry crosses one segment boundary per cycle. A single global advance
// signal stalls every stage at once.
// Optional feature: define ADD_SUB_SAT_EN to saturate ADD/SUB on signed overflow.
module cla_add_sub_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Rs1,
   input  logic [WIDTH-1:0] Rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             carry_out,
   output logic             zero
);

   localparam int unsigned NSEG = WIDTH / SEG_W;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_SLT  = 2'b10;
   localparam logic [1:0] OP_SLTU = 2'b11;

   // One SEG_W-bit lookahead block. Each carry is a flat sum of generate terms, not a ripple. Returns {cout, sum}.
   function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] a,
                                              input logic [SEG_W-1:0] b,
                                              input logic             cin);
      logic [SEG_W-1:0] g;
      logic [SEG_W-1:0] p;
      logic [SEG_W:0]   c;
      logic             t;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < int'(SEG_W); i++) begin
         t = cin;
         for (int j = 0; j <= i; j++) t = t & p[j];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return {c[SEG_W], p ^ c[SEG_W-1:0]};
   endfunction

   logic             adv;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             overflow_q;
   logic             carry_out_q;
   logic             zero_q;

   // Index k holds the inputs that stage k sees.
   logic             pv   [NSEG];
   logic             pc   [NSEG];
   logic [1:0]       pop  [NSEG];
   logic [WIDTH-1:0] pa   [NSEG];
   logic [WIDTH-1:0] pb   [NSEG];
   logic [WIDTH-1:0] psum [NSEG];

   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv & ~flush;

   // Stage 0 inputs. Every op except ADD subtracts: invert Rs2 and set carry-in to 1.
   assign pv[0]   = in_valid & in_ready;
   assign pc[0]   = (op != OP_ADD);
   assign pop[0]  = op;
   assign pa[0]   = Rs1;
   assign pb[0]   = (op == OP_ADD) ? Rs2 : ~Rs2;
   assign psum[0] = '0;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic [SEG_W:0]   seg;
      logic [WIDTH-1:0] sum_d;

      assign seg   = cla_seg(SEG_W'(pa[k] >> (k * SEG_W)), SEG_W'(pb[k] >> (k * SEG_W)), pc[k]);
      assign sum_d = psum[k] | (WIDTH'(seg[SEG_W-1:0]) << (k * SEG_W));

      if (k + 1 < NSEG) begin : g_mid
         logic             v_q;
         logic             c_q;
         logic [1:0]       op_q;
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] sum_q;

         // Stage register: holds on stall; flush kills only the valid.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               v_q   <= 1'b0;
               c_q   <= 1'b0;
               op_q  <= '0;
               a_q   <= '0;
               b_q   <= '0;
               sum_q <= '0;
            end else begin
               if (flush)    v_q <= 1'b0;
               else if (adv) v_q <= pv[k];
               if (adv) begin
                  c_q   <= seg[SEG_W];
                  op_q  <= pop[k];
                  a_q   <= pa[k];
                  b_q   <= pb[k];
                  sum_q <= sum_d;
               end
            end
         end

         assign pv[k+1]   = v_q;
         assign pc[k+1]   = c_q;
         assign pop[k+1]  = op_q;
         assign pa[k+1]   = a_q;
         assign pb[k+1]   = b_q;
         assign psum[k+1] = sum_q;
      end else begin : g_last
         logic             cin_msb;
         logic             ovf;
         logic             lt;
         logic [WIDTH-1:0] result_d;
         logic             overflow_d;
         logic             carry_out_d;
         logic             zero_d;

         // Flag derivation and op-dependent result selection.
         always_comb begin
            cin_msb     = seg[SEG_W-1] ^ pa[k][WIDTH-1] ^ pb[k][WIDTH-1];
            ovf         = seg[SEG_W] ^ cin_msb;
            lt          = (pop[k] == OP_SLT) ? (sum_d[WIDTH-1] ^ ovf) : ~seg[SEG_W];
            result_d    = sum_d;
            overflow_d  = ovf;
            carry_out_d = seg[SEG_W];
            case (pop[k])
               OP_ADD, OP_SUB: begin
`ifdef ADD_SUB_SAT_EN
                  if (ovf) begin
                     result_d = sum_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}};
                  end
`else
                  result_d = sum_d;
`endif
               end
               default: begin
                  result_d    = {{(WIDTH-1){1'b0}}, lt};
                  overflow_d  = 1'b0;
                  carry_out_d = 1'b0;
               end
            endcase
            zero_d = (result_d == '0);
         end

         // Output register: held while the consumer stalls.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               out_valid_q <= 1'b0;
               result_q    <= '0;
               overflow_q  <= 1'b0;
               carry_out_q <= 1'b0;
               zero_q      <= 1'b0;
            end else begin
               if (flush)    out_valid_q <= 1'b0;
               else if (adv) out_valid_q <= pv[k];
               if (adv) begin
                  result_q    <= result_d;
                  overflow_q  <= overflow_d;
                  carry_out_q <= carry_out_d;
                  zero_q      <= zero_d;
               end
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign carry_out = carry_out_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_add_sub_pipe.sv
// Directed testbench for cla_add_sub_pipe (WIDTH=32, SEG_W=8, latency 4).
module tb_cla_add_sub_pipe;

   localparam logic [1:0] ADD  = 2'b00;
   localparam logic [1:0] SUB  = 2'b01;
   localparam logic [1:0] SLT  = 2'b10;
   localparam logic [1:0] SLTU = 2'b11;

`ifdef ADD_SUB_SAT_EN
   localparam logic [31:0] SUB_OVF_EXP = 32'h8000_0000;
   localparam logic [31:0] ADD_OVF_EXP = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] SUB_OVF_EXP = 32'h7FFF_FFFF;
   localparam logic [31:0] ADD_OVF_EXP = 32'h8000_0000;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] Rs1 = '0;
   logic [31:0] Rs2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;
   logic        overflow;
   logic        carry_out;
   logic        zero;

   int nerr = 0;
   int nchk = 0;

   always #5 CLK = ~CLK;

   cla_add_sub_pipe #(.WIDTH(32), .SEG_W(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .Rs1       (Rs1),
      .Rs2       (Rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .carry_out (carry_out),
      .zero      (zero)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] r,
                          input logic ov, input logic co, input logic z);
      chk1({tag, "_valid"}, out_valid, v);
      chk32({tag, "_result"}, result, r);
      chk1({tag, "_ovf"}, overflow, ov);
      chk1({tag, "_cout"}, carry_out, co);
      chk1({tag, "_zero"}, zero, z);
   endtask

   task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      in_valid = v;
      op       = o;
      Rs1      = a;
      Rs2      = b;
   endtask

   // Issue one op, then wait until its result should be at the output.
   task automatic run1(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      drive(1'b1, o, a, b);
      tick;
      drive(1'b0, ADD, '0, '0);
      repeat (3) tick;
   endtask

   logic [31:0] exp4 [8];
   int sent;
   int recv;

   initial begin
      // Reset state
      out_ready = 1'b1;
      repeat (2) tick;
      chk_out("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      tick;

      // Carry across the segment 0->1 boundary, with the exact latency checked
      drive(1'b1, ADD, 32'h0000_00FF, 32'h0000_0001);
      tick;
      drive(1'b0, ADD, '0, '0);
      repeat (2) tick;
      chk1("t1_early", out_valid, 1'b0);
      tick;
      chk_out("t1", 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      tick;
      chk1("t1_drop", out_valid, 1'b0);

      // Unsigned wrap to zero through every segment
      run1(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      chk_out("t1b", 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);

      // Signed overflow, in both directions
      run1(SUB, 32'h8000_0000, 32'h0000_0001);
      chk_out("t2_sub", 1'b1, SUB_OVF_EXP, 1'b1, 1'b1, 1'b0);
      run1(ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      chk_out("t2_add", 1'b1, ADD_OVF_EXP, 1'b1, 1'b0, 1'b0);

      // Compare ops and a zero result, issued back to back
      drive(1'b1, SLT, 32'hFFFF_FFFF, 32'h0000_0001);
      tick;
      drive(1'b1, SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
      tick;
      drive(1'b1, SUB, 32'd5, 32'd5);
      tick;
      drive(1'b0, ADD, '0, '0);
      tick;
      chk_out("t3_slt", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
      tick;
      chk_out("t3_sltu", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
      tick;
      chk_out("t3_sub", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
      tick;

      // A stream of eight ADDs; the consumer stalls during cycles 6-9
      for (int i = 0; i < 8; i++) exp4[i] = 32'h0101_0101 * (i + 1) + 32'h00FF_00FF + i;
      sent = 0;
      recv = 0;
      for (int c = 0; c < 24; c++) begin
         out_ready = !(c >= 6 && c <= 9);
         if (sent < 8) drive(1'b1, ADD, 32'h0101_0101 * (sent + 1), 32'h00FF_00FF + sent);
         else          drive(1'b0, ADD, '0, '0);
         #1;
         if (c >= 6 && c <= 9) begin
            chk1("t4_hold_valid", out_valid, 1'b1);
            chk1("t4_stall_ready", in_ready, 1'b0);
         end
         if (out_valid) begin
            if (recv < 8) chk32("t4_result", result, exp4[recv]);
            if (out_ready) recv++;
         end
         if (in_valid && in_ready) sent++;
         tick;
      end
      out_ready = 1'b1;
      chk32("t4_sent", 32'(sent), 32'd8);
      chk32("t4_recv", 32'(recv), 32'd8);
      chk1("t4_idle", out_valid, 1'b0);

      // Flush with three ops in flight and a fourth offered
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ADD, 32'(i + 1), 32'd10);
         tick;
      end
      drive(1'b1, ADD, 32'd100, 32'd200);
      flush = 1'b1;
      #1;
      chk1("t5_ready", in_ready, 1'b0);
      tick;
      flush = 1'b0;
      drive(1'b0, ADD, '0, '0);
      for (int c = 0; c < 6; c++) begin
         chk1("t5_none", out_valid, 1'b0);
         tick;
      end
      run1(ADD, 32'd7, 32'd8);
      chk_out("t5_after", 1'b1, 32'd15, 1'b0, 1'b0, 1'b0);
      tick;

      // Asynchronous reset mid-stream
      drive(1'b1, ADD, 32'd1, 32'd2);
      repeat (5) tick;
      chk_out("t6_pre", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      #2;
      RST = 1'b1;
      #1;
      chk_out("t6_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, ADD, '0, '0);
      repeat (2) tick;
      #2;
      RST = 1'b0;
      #1;
      chk1("t6_in_ready", in_ready, 1'b1);
      for (int c = 0; c < 5; c++) begin
         chk1("t6_no_replay", out_valid, 1'b0);
         tick;
      end
      run1(ADD, 32'd1, 32'd1);
      chk_out("t6_fresh", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
